// File: rtl/icache_direct_pkg.sv
// ---------------------------------------------------------------------------
// icache_direct_pkg
//  Shared definitions for the direct-mapped instruction cache:
//  default geometry and the miss-handling FSM state type.
// ---------------------------------------------------------------------------
package icache_direct_pkg;

  localparam int DEF_INDEX_BITS = 7;   // 2**7 one-word lines
  localparam int DEF_ADDR_LEN   = 32;
  localparam int DEF_INST_LEN   = 32;

  // IDLE: serving hits / launching misses. WAIT: one miss outstanding.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/icache_direct_line_array.sv
// ---------------------------------------------------------------------------
// icache_direct_line_array
//  Tag + data storage and valid bits for the direct-mapped cache.
//  One combinational read port (indexed by the fetch address) and one
//  synchronous write port (the fill). Valid bits clear asynchronously on
//  rst=0; tag/data contents are never cleared.
// Ports:
//  clk, rst            clock, async active-low reset (valid bits only)
//  rd_idx              read line index
//  rd_valid/tag/data   contents of line rd_idx (combinational)
//  wr_en               write line wr_idx with wr_tag/wr_data, set valid
//  wr_idx/tag/data     write port
// ---------------------------------------------------------------------------
module icache_direct_line_array #(
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS   = 23,
  parameter int INST_LEN   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [INST_LEN-1:0]   rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [INST_LEN-1:0]   wr_data
);

  localparam int LINES = 2 ** INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [INST_LEN-1:0] data_mem [LINES];

  // One flop per valid bit so each line clears on reset independently of
  // the (unreset) storage arrays.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid[gi] <= 1'b0;
      end else if (wr_en && (wr_idx == INDEX_BITS'(gi))) begin
        valid[gi] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
//  Direct-mapped, read-only instruction cache between IF and mem_ctrl.
//  Hits are returned combinationally; a miss issues one registered word
//  request, waits for the fill pulse, writes the line and bypasses the word
//  to IF unless a flush arrived while waiting.
// Ports:
//  clk, rst                    clock, async active-low reset
//  if_req, if_pc, if_flush     fetch request / address / redirect
//  inst_valid, inst            fetched instruction (inst=0 when not valid)
//  icache_needed, icache_addr  registered miss request to mem_ctrl
//  inst_available_o, inst_icache  fill pulse and word from mem_ctrl
//  hit_cnt, miss_cnt           statistics counters
// Build option: define ICACHE_STATS_EN to get live hit/miss counters;
//  otherwise both counter ports read 0 and no counter flops exist.
// ---------------------------------------------------------------------------
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int ADDR_LEN   = DEF_ADDR_LEN,
  parameter int INST_LEN   = DEF_INST_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_LEN-1:0] if_pc,
  input  logic                if_flush,
  output logic                inst_valid,
  output logic [INST_LEN-1:0] inst,
  output logic                icache_needed,
  output logic [ADDR_LEN-1:0] icache_addr,
  input  logic                inst_available_o,
  input  logic [INST_LEN-1:0] inst_icache,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
);

  localparam int TAG_BITS = ADDR_LEN - INDEX_BITS - 2;

  state_t              state, state_next;
  logic                aborted, aborted_next;
  logic                needed_next;
  logic [ADDR_LEN-1:0] addr_next;
  logic                wr_en;
  logic                hit;
  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [INST_LEN-1:0] rd_data;

  icache_direct_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .INST_LEN   (INST_LEN)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (if_pc[INDEX_BITS+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (icache_addr[INDEX_BITS+1:2]),
    .wr_tag   (icache_addr[ADDR_LEN-1:INDEX_BITS+2]),
    .wr_data  (inst_icache)
  );

  assign hit = if_req && rd_valid && (rd_tag == if_pc[ADDR_LEN-1:INDEX_BITS+2]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      aborted       <= 1'b0;
      icache_needed <= 1'b0;
      icache_addr   <= '0;
    end else begin
      state         <= state_next;
      aborted       <= aborted_next;
      icache_needed <= needed_next;
      icache_addr   <= addr_next;
    end
  end

  always_comb begin
    state_next   = state;
    aborted_next = aborted;
    needed_next  = icache_needed;
    addr_next    = icache_addr;
    wr_en        = 1'b0;
    inst_valid   = 1'b0;
    inst         = '0;
    case (state)
      ST_IDLE: begin
        if (hit) begin
          inst_valid = 1'b1;
          inst       = rd_data;
        end else if (if_req && !if_flush) begin
          needed_next = 1'b1;
          addr_next   = if_pc;
          state_next  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (if_flush) aborted_next = 1'b1;
        if (inst_available_o) begin
          // The fill always lands in the array; only forwarding is gated.
          wr_en        = 1'b1;
          needed_next  = 1'b0;
          aborted_next = 1'b0;
          state_next   = ST_IDLE;
          // A flush coinciding with the fill also suppresses the bypass.
          if (!aborted && !if_flush && if_req && (if_pc == icache_addr)) begin
            inst_valid = 1'b1;
            inst       = inst_icache;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (state == ST_IDLE && hit) hit_cnt <= hit_cnt + 32'd1;
      if (state == ST_IDLE && state_next == ST_WAIT) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
